// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer/status blocks.
//   AE_LEVEL_DEFAULT : default almost-empty threshold
//   width_mask()     : all-ones mask of the requested width
//   bin2gray()       : binary to Gray code, width given by argument
//   gray2bin()       : Gray code to binary, width given by argument
// The conversion functions work on a 32-bit container. Bits above the
// requested width are forced to zero, so one function serves every
// pointer width up to 32.
package fifo_pkg;

    localparam int unsigned AE_LEVEL_DEFAULT = 4;

    function automatic logic [31:0] width_mask(input int unsigned w);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < w; i++) begin
            m = {m[30:0], 1'b1};
        end
        return m;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned w);
        logic [31:0] b;
        b = bin & width_mask(w);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    // Accumulating right-shifted copies builds that prefix in one pass.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned w);
        logic [31:0] g;
        logic [31:0] b;
        g = gray & width_mask(w);
        b = g;
        for (int unsigned i = 1; i < w; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin
// Purely combinational Gray-to-binary converter (XOR prefix from the MSB).
// It is shared by the read-side and write-side status blocks.
//   i_gray : W-bit Gray-coded value
//   o_bin  : W-bit binary equivalent
module fifo_gray2bin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = i_gray;
        for (int unsigned i = 1; i < W; i++) begin
            o_bin = o_bin ^ (i_gray >> i);
        end
    end

endmodule

// File: rtl/read_ptr_status.sv
// read_ptr_status
// Read-domain pointer and status logic for the asynchronous FIFO.
// It holds the binary read address and the Gray read pointer. From the
// synchronised Gray write pointer it derives registered empty, fill level,
// almost-empty and underflow flags, and it drives the RAM read enable
// together with a matching data-valid strobe.
//   rd_clk, rd_rstn   : read clock, async active-low reset
//   rd_en, clr_err    : read request, sticky-underflow clear
//   wr_ptr_sync       : Gray write pointer already synchronised to rd_clk
//   rd_addr, rd_ptr   : binary read address (low bits to RAM), Gray pointer
//   rd_fire           : RAM read enable (rd_en qualified by !empty)
//   rd_data_valid     : RAM output valid, one cycle after rd_fire
//   empty, almost_empty, rd_level : occupancy status
//   underflow, underflow_sticky   : read-while-empty pulse and latch
module read_ptr_status
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned AE_LEVEL   = AE_LEVEL_DEFAULT
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rd_en,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH:0]   wr_ptr_sync,
    output logic [ADDR_WIDTH:0]   rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  rd_fire,
    output logic                  rd_data_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow,
    output logic                  underflow_sticky
);

    localparam int unsigned      PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] r_rd_addr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_rd_level;
    logic             r_empty;
    logic             r_almost_empty;
    logic             r_rd_data_valid;
    logic             r_underflow;
    logic             r_underflow_sticky;

    logic             w_rd_fire;
    logic [PTR_W-1:0] w_rd_addr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_wr_bin;
    logic [PTR_W-1:0] w_level_next;
    logic             w_empty_next;
    logic             w_almost_empty_next;
    logic             w_underflow_next;

    fifo_gray2bin #(.W(PTR_W)) u_wr_gray2bin (
        .i_gray (wr_ptr_sync),
        .o_bin  (w_wr_bin)
    );

    // A read is honoured only against the registered empty flag. A read in
    // the cycle right after the last entry drains is therefore blocked.
    assign w_rd_fire      = rd_en & ~r_empty;
    assign w_rd_addr_next = r_rd_addr + PTR_W'(w_rd_fire);
    assign w_rd_ptr_next  = PTR_W'(bin2gray(32'(w_rd_addr_next), PTR_W));

    // Status is computed from the post-read pointer and the current write
    // pointer. A read and a write-pointer change in the same cycle then land
    // in one update. Modular subtraction absorbs the pointer wrap, and the
    // extra pointer bit lets a full FIFO read as 2**ADDR_WIDTH.
    assign w_level_next        = w_wr_bin - w_rd_addr_next;
    assign w_empty_next        = (wr_ptr_sync == w_rd_ptr_next);
    assign w_almost_empty_next = (w_level_next <= AE_THRESH);
    assign w_underflow_next    = rd_en & r_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            r_rd_addr  <= '0;
            r_rd_ptr   <= '0;
            r_rd_level <= '0;
        end else begin
            r_rd_addr  <= w_rd_addr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_rd_level <= w_level_next;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            r_empty            <= 1'b1;
            r_almost_empty     <= 1'b1;
            r_rd_data_valid    <= 1'b0;
            r_underflow        <= 1'b0;
            r_underflow_sticky <= 1'b0;
        end else begin
            r_empty            <= w_empty_next;
            r_almost_empty     <= w_almost_empty_next;
            r_rd_data_valid    <= w_rd_fire;
            r_underflow        <= w_underflow_next;
            // A new underflow takes priority over a simultaneous clear.
            r_underflow_sticky <= w_underflow_next | (r_underflow_sticky & ~clr_err);
        end
    end

    assign rd_addr          = r_rd_addr;
    assign rd_ptr           = r_rd_ptr;
    assign rd_fire          = w_rd_fire;
    assign rd_data_valid    = r_rd_data_valid;
    assign empty            = r_empty;
    assign almost_empty     = r_almost_empty;
    assign rd_level         = r_rd_level;
    assign underflow        = r_underflow;
    assign underflow_sticky = r_underflow_sticky;

endmodule
